// File: rtl/hamming_pkg.sv
// Shared helpers for the SECDED decoder: code geometry and data bit layout.
// Codeword bit 0 is overall parity; bits 1..N follow classic Hamming order.
package hamming_pkg;

  localparam int MAX_CW_W = 64;

  typedef enum logic [1:0] {
    CLS_CLEAN,
    CLS_SINGLE,
    CLS_DOUBLE
  } err_class_e;

  function automatic bit is_pow2(int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  function automatic int parity_bits(int dw);
    int p;
    p = 0;
    for (int i = 7; i >= 1; i--)
      if ((1 << i) >= dw + i + 1) p = i;
    return p;
  endfunction

  function automatic int code_n(int dw);
    return dw + parity_bits(dw);
  endfunction

  function automatic int code_w(int dw);
    return code_n(dw) + 1;
  endfunction

  // k-th position (ascending) that is not a power of two
  function automatic int data_pos(int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 3; i < MAX_CW_W; i++) begin
      if (!is_pow2(i)) begin
        if (cnt == k && pos == 0) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N      = code_n(DEF_DATA_W);
  localparam int DEF_CW_W   = code_w(DEF_DATA_W);

endpackage

// File: rtl/hamming_secded_syndrome.sv
// Combinational syndrome and overall parity of an extended Hamming codeword.
// Kept separate so an encoder-side checker can reuse it.
module hamming_secded_syndrome
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int P      = parity_bits(DATA_W),
  localparam int CW_W   = code_w(DATA_W)
) (
  input  logic [CW_W-1:0] codeword,
  output logic [P-1:0]    syndrome,
  output logic            pf
);

  always_comb begin
    syndrome = '0;
    for (int i = 1; i < CW_W; i++)
      if (codeword[i]) syndrome = syndrome ^ P'(i);
  end

  assign pf = ^codeword;

endmodule

// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage SECDED decoder with valid/ready flow control
// and saturating corrected/uncorrectable word counters.
module hamming_secded_decoder_pipe
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 16,
  localparam int P      = parity_bits(DATA_W),
  localparam int N      = code_n(DATA_W),
  localparam int CW_W   = code_w(DATA_W),
  localparam int POS_W  = $clog2(CW_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   codeword_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_single,
  output logic              err_double,
  output logic [POS_W-1:0]  err_pos,
  input  logic              clear_counts,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count
);

  localparam logic [P-1:0] N_P = P'(N);

  logic              s1_valid;
  logic              s2_valid;
  logic              s1_load;
  logic              s2_load;
  logic [CW_W-1:0]   s1_cw;
  logic [P-1:0]      s1_syn;
  logic              s1_pf;
  logic [P-1:0]      syn;
  logic              pf;
  err_class_e        cls;
  logic              flip;
  logic [POS_W-1:0]  fix_pos;
  logic [DATA_W-1:0] fixed_data;
  logic              syn_zero;
  logic              syn_in_range;
  logic              out_hs;
  logic              unused_parity;

  hamming_secded_syndrome #(
    .DATA_W(DATA_W)
  ) u_syn (
    .codeword(codeword_in),
    .syndrome(syn),
    .pf      (pf)
  );

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_hs   = s2_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
      s1_pf    <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      s1_cw    <= codeword_in;
      s1_syn   <= syn;
      s1_pf    <= pf;
    end
  end

  assign syn_zero     = (s1_syn == '0);
  assign syn_in_range = (s1_syn <= N_P);

  always_comb begin
    cls     = CLS_DOUBLE;
    flip    = 1'b0;
    fix_pos = '0;
    unique case (1'b1)
      syn_zero && !s1_pf: cls = CLS_CLEAN;
      syn_zero && s1_pf:  cls = CLS_SINGLE;
      !syn_zero && s1_pf && syn_in_range: begin
        cls     = CLS_SINGLE;
        flip    = 1'b1;
        fix_pos = POS_W'(s1_syn);
      end
      default: cls = CLS_DOUBLE;
    endcase
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    localparam int POS = data_pos(k);
    assign fixed_data[k] =
      s1_cw[POS] ^ (flip && (s1_syn == P'(POS)));
  end

  // parity positions only feed the syndrome, never the data
  assign unused_parity = ^s1_cw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      data_out   <= '0;
      err_single <= 1'b0;
      err_double <= 1'b0;
      err_pos    <= '0;
    end else if (s2_load) begin
      s2_valid   <= s1_valid;
      data_out   <= fixed_data;
      err_single <= s1_valid && (cls == CLS_SINGLE);
      err_double <= s1_valid && (cls == CLS_DOUBLE);
      err_pos    <= s1_valid ? fix_pos : '0;
    end
  end

  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (clear_counts) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (out_hs) begin
      if (err_single && corr_count != {CNT_W{1'b1}})
        corr_count <= corr_count + CNT_W'(1);
      if (err_double && uncorr_count != {CNT_W{1'b1}})
        uncorr_count <= uncorr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// Bench for hamming_secded_decoder_pipe at DATA_W=4, CNT_W=2: vector table,
// random backpressure stream against a nearest-codeword model, reset/counter cases.
module tb_hamming_secded_decoder_pipe;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = 3;

  typedef struct {
    logic [3:0] data;
    logic       s;
    logic       d;
    logic [2:0] pos;
  } exp_t;

  typedef struct {
    logic [7:0] cw;
    exp_t       e;
  } vec_t;

  typedef struct {
    exp_t e;
    int   stamp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] codeword_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data_out;
  logic       err_single;
  logic       err_double;
  logic [2:0] err_pos;
  logic       clear_counts;
  logic [1:0] corr_count;
  logic [1:0] uncorr_count;

  hamming_secded_decoder_pipe #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .codeword_in (codeword_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .err_single  (err_single),
    .err_double  (err_double),
    .err_pos     (err_pos),
    .clear_counts(clear_counts),
    .corr_count  (corr_count),
    .uncorr_count(uncorr_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  sb_t  q[$];
  int   exp_corr = 0;
  int   exp_uncorr = 0;
  bit   lat_chk = 0;
  bit   stall_prev = 0;
  bit   acc = 0;
  bit   use_tab = 0;
  exp_t tab_exp;
  logic [3:0] h_data;
  logic       h_s;
  logic       h_d;
  logic [2:0] h_pos;
  vec_t tv[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] encode(logic [3:0] d);
    logic [7:0] c;
    logic p;
    c = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    for (int j = 0; j < 3; j++) begin
      p = 1'b0;
      for (int i = 1; i < 8; i++)
        if ((i & (1 << j)) != 0) p ^= c[i];
      c[1 << j] = p;
    end
    c[0] = ^c[7:1];
    return c;
  endfunction

  // nearest-codeword decode: distance 0 clean, 1 single, otherwise double
  function automatic exp_t decode_ref(logic [7:0] cw);
    exp_t r;
    logic [7:0] diff;
    int best;
    best = -1;
    r.data = {cw[7], cw[6], cw[5], cw[3]};
    r.s = 1'b0;
    r.d = 1'b1;
    r.pos = '0;
    for (int d = 0; d < 16; d++) begin
      diff = cw ^ encode(4'(d));
      if ($countones(diff) <= 1) begin
        best = d;
        r.data = 4'(d);
        r.d = 1'b0;
        r.s = (diff != 0);
        for (int b = 0; b < 8; b++)
          if (diff[b]) r.pos = 3'(b);
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] gen_word();
    logic [7:0] c;
    int a;
    int b;
    c = encode(4'($urandom));
    case ($urandom % 4)
      0: ;
      1: c[$urandom % 8] ^= 1'b1;
      2: begin
        a = $urandom % 8;
        b = (a + 1 + ($urandom % 7)) % 8;
        c[a] ^= 1'b1;
        c[b] ^= 1'b1;
      end
      default: c = 8'($urandom);
    endcase
    return c;
  endfunction

  function automatic vec_t mk(logic [7:0] cw, logic [3:0] d,
                              logic s, logic dd, logic [2:0] p);
    vec_t v;
    v.cw = cw;
    v.e.data = d;
    v.e.s = s;
    v.e.d = dd;
    v.e.pos = p;
    return v;
  endfunction

  task automatic cycle();
    sb_t  ent;
    exp_t ex;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
    chk("corr_count", 32'(corr_count), 32'(exp_corr));
    chk("uncorr_count", 32'(uncorr_count), 32'(exp_uncorr));
    if (stall_prev) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(data_out), 32'(h_data));
      chk("hold_flags", 32'({err_single, err_double, err_pos}),
          32'({h_s, h_d, h_pos}));
    end
    acc = in_valid && in_ready;
    if (acc) begin
      ex = use_tab ? tab_exp : decode_ref(codeword_in);
      q.push_back('{e: ex, stamp: cyc});
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0h expected none (cycle %0d)",
                 data_out, cyc);
      end else begin
        ent = q.pop_front();
        chk("data_out", 32'(data_out), 32'(ent.e.data));
        chk("err_single", 32'(err_single), 32'(ent.e.s));
        chk("err_double", 32'(err_double), 32'(ent.e.d));
        chk("err_pos", 32'(err_pos), 32'(ent.e.pos));
        if (lat_chk) chk("latency", 32'(cyc - ent.stamp), 32'd2);
        if (ent.e.s && exp_corr < CNT_MAX) exp_corr++;
        if (ent.e.d && exp_uncorr < CNT_MAX) exp_uncorr++;
      end
    end
    if (clear_counts) begin
      exp_corr = 0;
      exp_uncorr = 0;
    end
    stall_prev = out_valid && !out_ready;
    h_data = data_out;
    h_s = err_single;
    h_d = err_double;
    h_pos = err_pos;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 30) begin
      cycle();
      n++;
    end
    chk(name, 32'(q.size()), 32'd0);
  endtask

  int sent;
  int guard;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    codeword_in = '0;
    out_ready = 1'b0;
    clear_counts = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_flags", 32'({err_single, err_double, err_pos}), 32'd0);
    chk("rst_counts", 32'({corr_count, uncorr_count}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    tv[0] = mk(8'hAA, 4'hB, 1'b0, 1'b0, 3'd0);
    tv[1] = mk(8'h8A, 4'hB, 1'b1, 1'b0, 3'd5);
    tv[2] = mk(8'hAB, 4'hB, 1'b1, 1'b0, 3'd0);
    tv[3] = mk(8'hCA, 4'hD, 1'b0, 1'b1, 3'd0);
    tv[4] = mk(8'h00, 4'h0, 1'b0, 1'b0, 3'd0);
    tv[5] = mk(8'hFF, 4'hF, 1'b0, 1'b0, 3'd0);
    tv[6] = mk(8'h7F, 4'hF, 1'b1, 1'b0, 3'd7);
    tv[7] = mk(8'h03, 4'h0, 1'b0, 1'b1, 3'd0);

    out_ready = 1'b1;
    lat_chk = 1'b1;
    use_tab = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tab_exp = tv[i].e;
      codeword_in = tv[i].cw;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (3) cycle();
    end
    use_tab = 1'b0;

    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      codeword_in = gen_word();
      cycle();
    end
    drain("drain_burst");
    lat_chk = 1'b0;

    clear_counts = 1'b1;
    cycle();
    clear_counts = 1'b0;

    sent = 0;
    guard = 0;
    while (sent < 40 && guard < 400) begin
      in_valid = ($urandom % 4) != 0;
      codeword_in = gen_word();
      out_ready = $urandom % 2;
      cycle();
      if (acc) sent++;
      guard++;
    end
    chk("random_sent", 32'(sent), 32'd40);
    drain("drain_random");

    clear_counts = 1'b1;
    cycle();
    clear_counts = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      codeword_in = encode(4'(i + 3)) ^ 8'(1 << (i + 1));
      cycle();
    end
    drain("drain_sat");
    cycle();
    chk("corr_saturated", 32'(corr_count), 32'd3);

    out_ready = 1'b0;
    in_valid = 1'b1;
    codeword_in = encode(4'h6) ^ 8'h10;
    cycle();
    in_valid = 1'b0;
    while (!out_valid && guard < 420) begin
      cycle();
      guard++;
    end
    clear_counts = 1'b1;
    out_ready = 1'b1;
    cycle();
    clear_counts = 1'b0;
    cycle();
    chk("clear_wins", 32'(corr_count), 32'd0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    codeword_in = encode(4'h9);
    cycle();
    codeword_in = encode(4'h2) ^ 8'h04;
    cycle();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    exp_corr = 0;
    exp_uncorr = 0;
    stall_prev = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    lat_chk = 1'b1;
    in_valid = 1'b1;
    codeword_in = encode(4'hC) ^ 8'h40;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
